// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave is the unit's view; master is the requester-plus-memory environment.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [31:0] mem_read_data;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_write_data, mem_write_enable
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_write_data, mem_write_enable
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data memory.
// Sub-word stores are done as read-modify-write; bad requests never reach memory.
module load_store_unit #(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   load_store_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t      state, state_nxt;
   logic        write_q, unsigned_q, error_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, word_q;
   logic        req_error, word_store;
   logic [31:0] merged_word, load_data;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign word_store = write_q && (size_q == 2'b10);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      req_error = 1'b0;
      unique case (bus.req_size)
         2'b00:   req_error = 1'b0;
         2'b01:   req_error = bus.req_addr[0];
         2'b10:   req_error = (bus.req_addr[1:0] != 2'b00);
         default: req_error = 1'b1;
      endcase
      if ({2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS)
         req_error = 1'b1;
   end

   // Little-endian lane replacement applied to the word read during ACCESS.
   always_comb begin
      merged_word = bus.mem_read_data;
      if (size_q == 2'b00)
         merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   assign byte_lane = word_q[{addr_q[1:0], 3'b000} +: 8];
   assign half_lane = word_q[{addr_q[1], 4'b0000} +: 16];

   always_comb begin
      unique case (size_q)
         2'b00:   load_data = unsigned_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         2'b01:   load_data = unsigned_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: load_data = word_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         error_q    <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            write_q    <= bus.req_write;
            unsigned_q <= bus.req_unsigned;
            error_q    <= req_error;
            size_q     <= bus.req_size;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
         end
         // Sub-word stores keep the already-merged word so WRITE drives memory from a register.
         if (state == ACCESS && !word_store)
            word_q <= write_q ? merged_word : bus.mem_read_data;
      end
   end

   always_comb begin
      state_nxt            = state;
      bus.req_ready        = 1'b0;
      bus.resp_valid       = 1'b0;
      bus.resp_rdata       = '0;
      bus.resp_error       = 1'b0;
      bus.mem_address      = '0;
      bus.mem_write_data   = '0;
      bus.mem_write_enable = 1'b0;
      unique case (state)
         IDLE: begin
            bus.req_ready = rst_n;
            if (bus.req_valid)
               state_nxt = req_error ? RESP : ACCESS;
         end
         ACCESS: begin
            bus.mem_address = {2'b00, addr_q[31:2]};
            if (word_store) begin
               bus.mem_write_enable = 1'b1;
               bus.mem_write_data   = wdata_q;
               state_nxt            = RESP;
            end else begin
               state_nxt = write_q ? WRITE : RESP;
            end
         end
         WRITE: begin
            bus.mem_address      = {2'b00, addr_q[31:2]};
            bus.mem_write_enable = 1'b1;
            bus.mem_write_data   = word_q;
            state_nxt            = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_error = error_q;
            bus.resp_rdata = (error_q || write_q) ? 32'h0 : load_data;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural word memory plus an
// in-order response scoreboard that also checks per-request latency.
module tb_load_store_unit;

   localparam int DEPTH = 1024;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   wr_count = 0;
   int   wr_cyc = 0;
   int   last_acc = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] mem [DEPTH];
   exp_t sb [$];

   load_store_unit_if bus ();

   load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (bus.mem_write_enable)
         mem[bus.mem_address[9:0]] <= bus.mem_write_data;

   always_comb bus.mem_read_data = mem[bus.mem_address[9:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Write log and response scoreboard, sampled away from the rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (bus.mem_write_enable) begin
         wr_count++;
         wr_addr = bus.mem_address;
         wr_data = bus.mem_write_data;
         wr_cyc  = cyc;
      end
      if (bus.resp_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("resp_error", {31'h0, bus.resp_error}, {31'h0, e.err});
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input int e_lat,
                       input logic keep);
      int guard = 0;
      exp_t e;
      bus.req_valid    = 1'b1;
      bus.req_write    = w;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      while (!bus.req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         check("accept_timeout", 32'd1, 32'd0);
      end else begin
         e.err = e_err; e.rdata = e_rd; e.lat = e_lat; e.acc = cyc;
         last_acc = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      if (!keep) bus.req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int guard = 0;
      do begin
         @(negedge clk);
         #1;
         guard++;
      end while ((sb.size() != 0 || !bus.req_ready) && guard < 60);
      if (guard >= 60) check("drain_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int wc, a0, a1;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;

      // Reset state
      #3;
      check("rst_we", {31'h0, bus.mem_write_enable}, 32'd0);
      check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
      check("rst_mem_addr", bus.mem_address, 32'd0);
      check("rst_mem_wdata", bus.mem_write_data, 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      #1 check("rst_ready", {31'h0, bus.req_ready}, 32'd1);
      @(negedge clk);

      // Word store then load
      wc = wr_count;
      send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b0);
      wait_done();
      check("ws_wr_count", 32'(wr_count - wc), 32'd1);
      check("ws_wr_addr", wr_addr, 32'd4);
      check("ws_wr_data", wr_data, 32'hDEADBEEF);
      check("ws_wr_cycle", 32'(wr_cyc - last_acc), 32'd1);
      send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1'b0);
      wait_done();

      // Byte store read-modify-write
      send(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0, 2, 1'b0);
      wait_done();
      wc = wr_count;
      send(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 1'b0, 32'h0, 3, 1'b0);
      check("bs_read_we", {31'h0, bus.mem_write_enable}, 32'd0);
      check("bs_read_addr", bus.mem_address, 32'd4);
      wait_done();
      check("bs_wr_count", 32'(wr_count - wc), 32'd1);
      check("bs_wr_data", wr_data, 32'h11AA3344);
      check("bs_wr_cycle", 32'(wr_cyc - last_acc), 32'd2);
      check("bs_mem4", mem[4], 32'h11AA3344);
      send(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 1'b0);
      send(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'h000000AA, 2, 1'b0);
      wait_done();

      // Halfword store into upper lane, then loads
      send(1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, 2, 1'b0);
      send(1'b1, 2'b01, 1'b0, 32'h16, 32'h00008001, 1'b0, 32'h0, 3, 1'b0);
      wait_done();
      check("hs_wr_data", wr_data, 32'h80010000);
      check("hs_wr_addr", wr_addr, 32'd5);
      send(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0, 32'hFFFF8001, 2, 1'b0);
      send(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0, 32'h00008001, 2, 1'b0);
      send(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h00000033, 2, 1'b0);
      wait_done();

      // Errors: misaligned word, misaligned half, illegal size, out of range
      wc = wr_count;
      send(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1, 1'b0);
      send(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF, 1'b1, 32'h0, 1, 1'b0);
      send(1'b1, 2'b11, 1'b0, 32'h0, 32'h1234, 1'b1, 32'h0, 1, 1'b0);
      send(1'b1, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h5555, 1'b1, 32'h0, 1, 1'b0);
      send(1'b0, 2'b10, 1'b0, 32'(4 * DEPTH - 4), 32'h0, 1'b0, 32'hx, 2, 1'b0);
      wait_done();
      check("err_no_write", 32'(wr_count - wc), 32'd0);

      // Reset during the read phase of a byte store
      send(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0, 2, 1'b0);
      wait_done();
      wc = wr_count;
      send(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055, 1'b0, 32'h0, 3, 1'b0);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      check("mr_we", {31'h0, bus.mem_write_enable}, 32'd0);
      check("mr_addr", bus.mem_address, 32'd0);
      check("mr_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1 check("mr_ready", {31'h0, bus.req_ready}, 32'd1);
      repeat (5) @(negedge clk);
      #1;
      check("mr_no_write", 32'(wr_count - wc), 32'd0);
      check("mr_mem4", mem[4], 32'h11223344);

      // Hold-off: req_valid stays high across three loads
      send(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'h80010000, 2, 1'b1);
      a0 = last_acc;
      send(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 1'b0, 32'h00000080, 2, 1'b1);
      a1 = last_acc;
      check("ho_spacing1", 32'(a1 - a0), 32'd3);
      send(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h00001122, 2, 1'b0);
      check("ho_spacing2", 32'(last_acc - a1), 32'd3);
      wait_done();
      check("ho_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
